// File: rtl/uart_pkg.sv
// uart_pkg: types, constants and helpers shared by the UART transmitter and,
// later, the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned UART_STOP_BITS = 1;

  // Whole clocks per bit; the fractional part is dropped.
  function automatic int unsigned clks_per_bit(input int unsigned freq, input int unsigned baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered occupancy count.
// Pushes while full and pops while empty are ignored, so nothing is overwritten.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  // Storage array; contents are only meaningful where count says so, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/serial_tx.sv
// serial_tx: FIFO-buffered UART transmitter, 8N1 by default.
// Define SERIAL_TX_PARITY_EN to add an even parity bit (8E1).
// tx is registered from the current state, so the line lags the FSM by one clock.
module serial_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned CW  = (CPB > 2) ? $clog2(CPB) : 1;

  if (CPB < 2) begin : g_bad_baud
    $error("serial_tx: CLK_FREQ / BAUD must be at least 2");
  end

  uart_tx_state_t            state;
  uart_tx_state_t            state_n;
  logic [CW-1:0]             baud_cnt;
  logic                      bit_end;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shift;
  logic                      tx_n;
  logic                      pop;
  logic                      push;
  logic [UART_DATA_BITS-1:0] fifo_rdata;
  logic                      fifo_full;
  logic                      fifo_empty;

  assign in_ready = !fifo_full && !rst;
  assign push     = in_valid && in_ready;
  assign busy     = (state != IDLE) || !fifo_empty;
  assign bit_end  = (baud_cnt == CW'(CPB - 1));

  sync_fifo #(
    .WIDTH(UART_DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .wdata(in_data),
    .pop  (pop),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

`ifdef SERIAL_TX_PARITY_EN
  logic par_bit;

  // Parity is taken from the byte as popped, before shifting destroys it.
  always_ff @(posedge clk) begin
    if (rst)      par_bit <= 1'b0;
    else if (pop) par_bit <= ^fifo_rdata;
  end
`endif

  // Next state, pop request and the line level for the current state.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    tx_n    = 1'b1;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = START;
        end
      end
      START: begin
        tx_n = 1'b0;
        if (bit_end) state_n = DATA;
      end
      DATA: begin
        tx_n = shift[0];
        if (bit_end && bit_idx == 3'(UART_DATA_BITS - 1)) begin
`ifdef SERIAL_TX_PARITY_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        tx_n = par_bit;
        if (bit_end) state_n = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, bit timing, data shifting and the registered line output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      state <= state_n;
      tx    <= tx_n;
      // Every non-idle state exits on bit_end, so this also clears on state entry.
      if (state == IDLE || bit_end) baud_cnt <= '0;
      else                          baud_cnt <= baud_cnt + 1'b1;
      if (state == START)             bit_idx <= '0;
      else if (state == DATA && bit_end) bit_idx <= bit_idx + 1'b1;
      if (pop)                           shift <= fifo_rdata;
      else if (state == DATA && bit_end) shift <= shift >> 1;
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed table, hand-written corner sequences and random bytes
// checked against a line decoder and an accepted-byte queue.
module tb_serial_tx;

  localparam int CPB = 16;
`ifdef SERIAL_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FT = NB * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       tx;
  logic       busy;

  serial_tx #(.CLK_FREQ(1600), .BAUD(100), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int mon_n = 0;
  int fstart = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int start_q[$];
  logic samp [FT];

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Judge one captured frame: constant level per bit, framing, data vs model.
  task automatic check_frame();
    logic [NB-1:0] bv;
    logic [7:0] d;
    logic [7:0] e;
    int incons;
    incons = 0;
    for (int k = 0; k < NB; k++) begin
      bv[k] = samp[k*CPB];
      for (int j = 1; j < CPB; j++) if (samp[k*CPB+j] !== bv[k]) incons++;
    end
    chk("bit_width", incons, 0);
    chk("start_stop", int'({bv[NB-1], bv[0]}), 2);
    d = bv[8:1];
    if (exp_q.size() == 0) chk("unexpected_frame", int'(d), -1);
    else begin
      e = exp_q.pop_front();
      chk("frame_data", int'(d), int'(e));
`ifdef SERIAL_TX_PARITY_EN
      chk("frame_parity", int'(bv[9]), int'(^e));
`endif
    end
    rx_q.push_back(d);
    start_q.push_back(fstart);
  endtask

  // Line decoder and accepted-byte model, sampled with pre-edge values.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      mon_n = 0;
    end else begin
      if (in_valid && in_ready) exp_q.push_back(in_data);
      if (mon_n > 0 || tx == 1'b0) begin
        if (mon_n == 0) fstart = cyc;
        samp[mon_n] = tx;
        mon_n++;
        if (mon_n == FT) begin
          check_frame();
          mon_n = 0;
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] b, output int acc);
    logic rdy;
    int n;
    n = 0;
    acc = -1;
    in_data = b;
    in_valid = 1'b1;
    while (acc < 0 && n < 4000) begin
      rdy = in_ready;
      tick();
      n++;
      if (rdy) acc = cyc;
    end
    if (acc < 0) chk("push_timeout", n, 0);
  endtask

  task automatic wait_rx(input int n, input string name);
    int k;
    k = 0;
    while (rx_q.size() < n && k < 20000) begin
      tick();
      k++;
    end
    chk(name, rx_q.size(), n);
  endtask

  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;   // line order: [0] start, [8:1] data, [9] parity, [10] stop
  } vec_t;

  vec_t vecs[6];

  initial begin
    int a0, a1, a2, errs, bi;
    int acc6[6];
    logic [10:0] fr;

    vecs[0] = '{8'h55, {1'b1, 1'b0, 8'h55, 1'b0}};
    vecs[1] = '{8'h07, {1'b1, 1'b1, 8'h07, 1'b0}};
    vecs[2] = '{8'h00, {1'b1, 1'b0, 8'h00, 1'b0}};
    vecs[3] = '{8'hFF, {1'b1, 1'b0, 8'hFF, 1'b0}};
    vecs[4] = '{8'h80, {1'b1, 1'b1, 8'h80, 1'b0}};
    vecs[5] = '{8'hA5, {1'b1, 1'b0, 8'hA5, 1'b0}};

    // reset state
    repeat (3) tick();
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", in_ready, 1);
    tick();

    // single bytes: latency, exact bit widths, busy
    for (int v = 0; v < 6; v++) begin
      fr = vecs[v].frame;
      push_byte(vecs[v].data, a0);
      in_valid = 1'b0;
      chk("busy_after_accept", busy, 1);
      chk("lat_idle1", tx, 1);
      tick();
      chk("lat_idle2", tx, 1);
      errs = 0;
      for (int k = 0; k < NB; k++) begin
        bi = (k == NB - 1) ? 10 : k;
        for (int j = 0; j < CPB; j++) begin
          tick();
          if (tx !== fr[bi]) errs++;
        end
      end
      chk("vec_wave", errs, 0);
      tick();
      chk("busy_end", busy, 0);
      chk("tx_idle_end", tx, 1);
      repeat (5) tick();
    end

    // back-to-back frames abut
    rx_q.delete();
    start_q.delete();
    push_byte(8'hA5, a0);
    push_byte(8'h3C, a1);
    push_byte(8'hFF, a2);
    in_valid = 1'b0;
    chk("b2b_accept", a2 - a0, 2);
    wait_rx(3, "b2b_rx");
    if (rx_q.size() >= 3) begin
      chk("b2b_ord0", rx_q[0], 8'hA5);
      chk("b2b_ord1", rx_q[1], 8'h3C);
      chk("b2b_ord2", rx_q[2], 8'hFF);
      chk("b2b_gap1", start_q[1] - start_q[0], FT);
      chk("b2b_gap2", start_q[2] - start_q[1], FT);
    end
    repeat (5) tick();

    // FIFO full stall
    rx_q.delete();
    for (int b = 1; b <= 6; b++) begin
      push_byte(8'(b), acc6[b-1]);
      if (b == 5) chk("full_ready_low", in_ready, 0);
    end
    in_valid = 1'b0;
    chk("fill_time", acc6[4] - acc6[0], 4);
    chk("sixth_accept", acc6[5] - acc6[0], FT + 2);
    wait_rx(6, "full_rx");
    errs = 0;
    for (int i = 0; i < 6 && i < rx_q.size(); i++) if (rx_q[i] != 8'(i + 1)) errs++;
    chk("full_order", errs, 0);
    repeat (5) tick();

    // reset during data bit 3 of 0x81 with two bytes queued
    rx_q.delete();
    push_byte(8'h81, a0);
    push_byte(8'h11, a1);
    push_byte(8'h22, a2);
    in_valid = 1'b0;
    while (cyc < a0 + 70) tick();
    chk("pre_rst_tx_low", tx, 0);
    rst = 1'b1;
    #1;
    chk("ready_in_rst", in_ready, 0);
    tick();
    rst = 1'b0;
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_busy", busy, 0);
    errs = 0;
    for (int i = 0; i < 3 * FT; i++) begin
      tick();
      if (tx !== 1'b1) errs++;
    end
    chk("rst_quiet", errs, 0);
    chk("rst_no_rx", rx_q.size(), 0);
    push_byte(8'h42, a0);
    in_valid = 1'b0;
    wait_rx(1, "post_rst_rx");
    if (rx_q.size() >= 1) chk("post_rst_data", rx_q[0], 8'h42);
    repeat (5) tick();

    // random bytes with random gaps, checked by the decoder against the model
    rx_q.delete();
    for (int i = 0; i < 20; i++) begin
      push_byte(8'($urandom_range(0, 255)), a0);
      if ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 200)) tick();
      end
    end
    in_valid = 1'b0;
    wait_rx(20, "rand_rx");
    chk("model_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
